// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch slice.
package fetch_pkg;

  localparam int DWIDTH_DEF = 16;
  localparam int AWIDTH_DEF = 16;
  localparam int QDEPTH_DEF = 4;

  localparam logic [3:0] HALT_OPCODE = 4'hF;

  typedef struct packed {
    logic [AWIDTH_DEF-1:0] pc;
    logic [DWIDTH_DEF-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Circular prefetch queue of {pc, instr} entries with push/pop/flush.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int QDEPTH = QDEPTH_DEF,
  localparam int PW = $clog2(QDEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [AWIDTH-1:0] push_pc,
  input  logic [DWIDTH-1:0] push_instr,
  input  logic              pop,
  input  logic              flush,
  output logic [CW-1:0]     count,
  output logic [AWIDTH-1:0] head_pc,
  output logic [DWIDTH-1:0] head_instr
);

  logic [AWIDTH-1:0] pc_mem    [QDEPTH];
  logic [DWIDTH-1:0] instr_mem [QDEPTH];
  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     tail_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail_ptr]    <= push_pc;
      instr_mem[tail_ptr] <= push_instr;
    end
  end

  assign head_pc    = pc_mem[head_ptr];
  assign head_instr = instr_mem[head_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, redirect and optional HALT stop over a prefetch queue.
// Optional feature: define FETCH_HALT_EN to stop fetching after a HALT opcode word.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int QDEPTH = QDEPTH_DEF,
  parameter logic [AWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [AWIDTH-1:0] mem_addr,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [DWIDTH-1:0] mem_data_in,
  input  logic [DWIDTH-1:0] mem_data_out,
  input  logic              redirect,
  input  logic [AWIDTH-1:0] redirect_pc,
  output logic              instr_valid,
  output logic [DWIDTH-1:0] instr,
  output logic [AWIDTH-1:0] instr_pc,
  input  logic              instr_ready,
  output logic              halted
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0]     FULL   = CW'(QDEPTH);
  localparam logic [AWIDTH-1:0] PC_RST = {RESET_PC[AWIDTH-1:1], 1'b0};

  logic [AWIDTH-1:0] pc;
  logic [CW-1:0]     count;
  logic              pop;

  assign mem_wr      = 1'b0;
  assign mem_data_in = '0;
  assign mem_addr    = pc;

  always_comb begin
    mem_enable = !rst && !redirect && !halted && (count < FULL);
  end

  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             pc <= PC_RST;
    else if (redirect)   pc <= {redirect_pc[AWIDTH-1:1], 1'b0};
    else if (mem_enable) pc <= pc + AWIDTH'(2);
  end

`ifdef FETCH_HALT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           halted <= 1'b0;
    else if (redirect) halted <= 1'b0;
    else if (mem_enable && (mem_data_out[15:12] == HALT_OPCODE)) halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif

  fetch_queue #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (mem_enable),
    .push_pc    (pc),
    .push_instr (mem_data_out),
    .pop        (pop),
    .flush      (redirect),
    .count      (count),
    .head_pc    (instr_pc),
    .head_instr (instr)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against a queue model.
module tb_fetch_unit;

  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] mem_addr;
  logic        mem_enable;
  logic        mem_wr;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic        halted;

  int unsigned checks = 0;
  int unsigned passed = 0;
  bit          halt_mode = 1'b0;

  // reference state: fetch address, delivered-order queue of {pc, instr}, halt flag
  logic [15:0] m_pc;
  logic [31:0] m_q[$];
  bit          m_halted;

  always #5 clk = ~clk;

  fetch_unit #(
    .DWIDTH   (16),
    .AWIDTH   (16),
    .QDEPTH   (QD),
    .RESET_PC (16'h0000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_enable   (mem_enable),
    .mem_wr       (mem_wr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .halted       (halted)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] idx;
    idx = (a >> 1) + 16'd1;
    if (halt_mode && a == 16'h0006) return 16'hF000;
    return idx * 16'h1111;
  endfunction

  always_comb mem_data_out = mem_word(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // One clock cycle: drive inputs at negedge, compare, then advance the model past the posedge.
  task automatic cycle(input bit rs, input bit rd, input logic [15:0] rp, input bit rdy);
    bit exp_en;
    @(negedge clk);
    rst = rs; redirect = rd; redirect_pc = rp; instr_ready = rdy;
    #1;
    if (rs) begin
      chk("rst_mem_enable", {31'b0, mem_enable}, 32'd0);
      chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
      m_q.delete();
      m_pc = 16'h0000;
      m_halted = 1'b0;
      return;
    end
    exp_en = !m_halted && !rd && (m_q.size() < QD);
    chk("mem_enable", {31'b0, mem_enable}, {31'b0, exp_en});
    if (exp_en) chk("mem_addr", {16'b0, mem_addr}, {16'b0, m_pc});
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_q.size() != 0});
    if (m_q.size() != 0) chk("head", {instr_pc, instr}, m_q[0]);
    chk("halted", {31'b0, halted}, {31'b0, m_halted});
    chk("mem_wr_data", {15'b0, mem_wr, mem_data_in}, 32'd0);
    if (rdy && m_q.size() != 0) void'(m_q.pop_front());
    if (rd) begin
      m_q.delete();
      m_pc = rp & 16'hFFFE;
      m_halted = 1'b0;
    end else if (exp_en) begin
      m_q.push_back({m_pc, mem_word(m_pc)});
`ifdef FETCH_HALT_EN
      if (mem_word(m_pc) >> 12 == 16'hF) m_halted = 1'b1;
`endif
      m_pc = m_pc + 16'd2;
    end
  endtask

  initial begin
    // reset then release with decode always ready
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("first_instr", {instr_pc, instr}, {16'h0000, 16'h1111});
    repeat (6) cycle(0, 0, 0, 1);

    // backpressure: fill, stall, single pop, single refetch at 0x0008
    cycle(1, 0, 0, 0);
    repeat (7) cycle(0, 0, 0, 0);
    chk("full_no_fetch", {31'b0, mem_enable}, 32'd0);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);

    // redirect to odd address while full
    cycle(0, 1, 16'h0041, 0);
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 1);
    chk("redir_head_pc", {16'b0, instr_pc}, 32'h0040);
    repeat (3) cycle(0, 0, 0, 1);

    // address wrap
    cycle(0, 1, 16'hFFFE, 1);
    cycle(0, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("wrap_head_pc", {16'b0, instr_pc}, 32'hFFFE);
    cycle(0, 0, 0, 1);
    chk("wrap_next_pc", {16'b0, instr_pc}, 32'h0000);
    repeat (2) cycle(0, 0, 0, 1);

    // HALT word at 0x0006
    halt_mode = 1'b1;
    cycle(1, 0, 0, 1);
    repeat (8) cycle(0, 0, 0, 1);
    halt_mode = 1'b0;
    cycle(0, 1, 16'h0100, 1);
    repeat (3) cycle(0, 0, 0, 1);

    // reset mid-stream
    cycle(1, 0, 0, 1);
    repeat (4) cycle(0, 0, 0, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bit rs, rd, rdy;
      rs  = ($urandom_range(0, 49) == 0);
      rd  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      cycle(rs, rd, 16'($urandom), rdy);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
